// File: rtl/conv_host_pkg.sv
// conv_host_pkg: shared types and constants for the convolution host.
// Bank select encodings, memory depths, data width, FSM states and
// small helpers used by the protocol checker (CONV_HOST_PROTOCOL_CHECK_EN).
package conv_host_pkg;

  localparam int DATA_W    = 20;
  localparam int ADDR_W    = 12;
  localparam int IMG_DEPTH = 4096;
  localparam int L0_DEPTH  = 4096;
  localparam int L1_DEPTH  = 1024;
  localparam int L2_DEPTH  = 2048;
  localparam int NUM_BANKS = 5;

  localparam logic [23:0] CYC_MAX = 24'hFFFFFF;

  typedef enum logic [2:0] {
    NOSEL = 3'd0,
    L0K0  = 3'd1,
    L0K1  = 3'd2,
    L1K0  = 3'd3,
    L1K1  = 3'd4,
    L2    = 3'd5
  } csel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Depth of the bank addressed by a given select code (1..5).
  function automatic int bank_depth(input int sel);
    case (sel)
      1, 2:    return L0_DEPTH;
      3, 4:    return L1_DEPTH;
      default: return L2_DEPTH;
    endcase
  endfunction

  // Select codes that name a real bank.
  function automatic logic sel_valid(input logic [2:0] s);
    return (s >= 3'd1) && (s <= 3'd5);
  endfunction

  // Address beyond the depth of the smaller L1/L2 banks.
  function automatic logic addr_over(input logic [2:0] s, input logic [ADDR_W-1:0] a);
    case (s)
      L1K0, L1K1: return |a[11:10];
      L2:         return a[11];
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/conv_host_bank.sv
// conv_host_bank: DEPTH x DATA_W memory, one synchronous write port and two
// asynchronous read ports. Contents are never reset.
module conv_host_bank
  import conv_host_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port, takes effect at the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/conv_host.sv
// conv_host: host side of the convolution accelerator. Holds the image and
// the five layer banks, runs the start/ready/busy handshake, measures run
// length and serves readback while the accelerator is idle.
// Optional protocol checker: define CONV_HOST_PROTOCOL_CHECK_EN.
module conv_host
  import conv_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic              busy,
  input  logic [11:0]       iaddr,
  output logic [19:0]       idata,
  input  logic              cwr,
  input  logic [11:0]       caddr_wr,
  input  logic [19:0]       cdata_wr,
  input  logic              crd,
  input  logic [11:0]       caddr_rd,
  output logic [19:0]       cdata_rd,
  input  logic [2:0]        csel,
  input  logic              ld_we,
  input  logic [11:0]       ld_addr,
  input  logic [19:0]       ld_data,
  input  logic              rb_req,
  input  logic [2:0]        rb_sel,
  input  logic [11:0]       rb_addr,
  output logic [19:0]       rb_data,
  output logic              rb_valid,
  output logic              done,
  output logic [23:0]       cycles,
  output logic              err
);

  state_e state_q, state_d;
  logic              ready_q, done_q, rb_valid_q;
  logic [23:0]       cycles_q;
  logic [DATA_W-1:0] rb_data_q;
  logic              idle_like;
  logic [DATA_W-1:0] img_rb;
  logic [DATA_W-1:0] rb_mux;
  logic [NUM_BANKS:1][DATA_W-1:0] bank_rd;
  logic [NUM_BANKS:1][DATA_W-1:0] bank_rb;

  // Preload and readback are only allowed while the accelerator is not using memory.
  assign idle_like = (state_q == IDLE) || (state_q == DONE);

  conv_host_bank #(.DEPTH(IMG_DEPTH)) u_image (
    .clk     (clk),
    .we      (ld_we && idle_like),
    .waddr   (ld_addr),
    .wdata   (ld_data),
    .raddr_a (iaddr),
    .rdata_a (idata),
    .raddr_b (rb_addr),
    .rdata_b (img_rb)
  );

  genvar gi;
  generate
    for (gi = 1; gi <= NUM_BANKS; gi++) begin : g_bank
      localparam int BD  = bank_depth(gi);
      localparam int BAW = $clog2(BD);
      // Narrow banks see only the low address bits, so out-of-range addresses alias.
      conv_host_bank #(.DEPTH(BD)) u_bank (
        .clk     (clk),
        .we      (cwr && (csel == 3'(gi))),
        .waddr   (caddr_wr[BAW-1:0]),
        .wdata   (cdata_wr),
        .raddr_a (caddr_rd[BAW-1:0]),
        .rdata_a (bank_rd[gi]),
        .raddr_b (rb_addr[BAW-1:0]),
        .rdata_b (bank_rb[gi])
      );
    end
  endgenerate

  // Layer read mux: zero unless a read strobe targets a real bank.
  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      for (int i = 1; i <= NUM_BANKS; i++) begin
        if (csel == 3'(i)) cdata_rd = bank_rd[i];
      end
    end
  end

  // Readback mux: select 0 is the image, 1..5 the banks, anything else reads zero.
  always_comb begin
    rb_mux = '0;
    if (rb_sel == 3'd0) rb_mux = img_rb;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      if (rb_sel == 3'(i)) rb_mux = bank_rb[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; start is only honoured when no run is in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = REQ;
      REQ:        if (busy)  state_d = RUN;
      RUN:        if (!busy) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Registered handshake/status flags follow the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == REQ);
      done_q  <= (state_d == DONE);
    end
  end

  // Run-length counter: cleared when a run is requested, counts RUN cycles, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
    end else if ((state_q != REQ) && (state_d == REQ)) begin
      cycles_q <= '0;
    end else if ((state_q == RUN) && (cycles_q != CYC_MAX)) begin
      cycles_q <= cycles_q + 24'd1;
    end
  end

  // Readback: one-cycle registered response, suppressed while a run owns the memories.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      rb_valid_q <= rb_req && idle_like;
      if (rb_req && idle_like) rb_data_q <= rb_mux;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign cycles   = cycles_q;
  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;

`ifdef CONV_HOST_PROTOCOL_CHECK_EN
  logic err_q;
  logic viol;

  // Any illegal layer access in this cycle.
  always_comb begin
    viol = 1'b0;
    if (cwr && crd) viol = 1'b1;
    if ((cwr || crd) && !sel_valid(csel)) viol = 1'b1;
    if ((cwr || crd) && (state_q != RUN)) viol = 1'b1;
    if (cwr && addr_over(csel, caddr_wr)) viol = 1'b1;
    if (crd && addr_over(csel, caddr_rd)) viol = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/conv_host.md
CONV_HOST -- requirements
Module: conv_host

Interface
REQ-001 The block SHALL have the following ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a run.
- ready  out  1  start request to the accelerator.
- busy  in  1  accelerator running.
- iaddr  in  12  image read address.
- idata  out  20  image data, signed Q4.16.
- cwr  in  1  layer write strobe.
- caddr_wr  in  12  layer write address.
- cdata_wr  in  20  layer write data.
- crd  in  1  layer read strobe.
- caddr_rd  in  12  layer read address.
- cdata_rd  out  20  layer read data.
- csel  in  3  bank select.
- ld_we  in  1  image preload write enable.
- ld_addr  in  12  image preload address.
- ld_data  in  20  image preload data.
- rb_req  in  1  readback request.
- rb_sel  in  3  readback bank.
- rb_addr  in  12  readback address.
- rb_data  out  20  readback data.
- rb_valid  out  1  readback data valid.
- done  out  1  run complete.
- cycles  out  24  run length in cycles.
- err  out  1  sticky protocol error.

Function
REQ-002 Memories SHALL be: image 4096x20; bank 1 and bank 2 (L0) 4096x20; bank 3 and bank 4 (L1) 1024x20, indexed by address[9:0]; bank 5 (L2) 2048x20, indexed by address[10:0].
REQ-003 idata SHALL be a combinational read of image[iaddr].
REQ-004 When crd=1 and csel is in 1..5, cdata_rd SHALL be a combinational read of bank[csel] at caddr_rd; otherwise cdata_rd SHALL be 0.
REQ-005 When cwr=1 and csel is in 1..5, bank[csel] at caddr_wr SHALL take cdata_wr at the rising clock edge; when csel is 0, 6 or 7 the write SHALL be dropped.
REQ-006 The FSM SHALL have states IDLE, REQ, RUN and DONE.
- IDLE or DONE, start=1: go to REQ.
- REQ: ready=1; go to RUN on the first cycle with busy=1.
- RUN: ready=0; go to DONE on the first cycle with busy=0.
- DONE: done=1 and holds; done clears on entry to REQ.
REQ-007 ready SHALL be registered and SHALL rise the cycle after start is accepted.
REQ-008 cycles SHALL clear on entry to REQ, SHALL increment once per cycle in RUN, SHALL saturate at 24'hFFFFFF, and SHALL hold in DONE.
REQ-009 ld_we SHALL write image[ld_addr] only in IDLE or DONE, and SHALL be ignored in REQ and RUN.
REQ-010 In IDLE or DONE, rb_req SHALL give rb_data = bank[rb_sel] at rb_addr, with rb_sel=0 selecting the image, and rb_valid=1 exactly one cycle later (registered).
REQ-011 In REQ or RUN, rb_req SHALL be ignored and rb_valid SHALL stay 0.
REQ-012 A start pulse in REQ or RUN SHALL be ignored.

Reset
REQ-013 Reset SHALL force the FSM to IDLE and ready=0, done=0, rb_valid=0, rb_data=0, cycles=0, err=0.
REQ-014 Memory contents SHALL NOT be cleared by reset; a reset during RUN SHALL abandon the run with memory contents preserved.

Configuration
REQ-015 With CONV_HOST_PROTOCOL_CHECK_EN defined, err SHALL set and hold until reset on any of:
- cwr and crd both high in the same cycle;
- cwr or crd high with csel outside 1..5;
- cwr or crd high outside RUN;
- an L1 or L2 access whose address exceeds the bank depth.
REQ-016 Without CONV_HOST_PROTOCOL_CHECK_EN, err SHALL be tied to 0 and no checker logic SHALL be built.

Structure
REQ-017 Package conv_host_pkg SHALL hold the csel encodings (NOSEL=0, L0K0=1, L0K1=2, L1K0=3, L1K1=4, L2=5), the bank depths, the data width of 20 and the FSM state encoding.
REQ-018 One sub-module, conv_host_bank, SHALL be used: a parameterised-depth memory with one synchronous write and two asynchronous read ports, instantiated once per bank and once for the image.

Verification
REQ-019 Preload: ld_we writes image[0x041]=20'h12345, then iaddr=0x041 -> idata=20'h12345 in the same cycle.
REQ-020 Handshake: start pulse -> ready=1 next cycle; busy rises 3 cycles later -> ready=0; busy held 100 cycles then falls -> done=1, cycles=100.
REQ-021 Banked write: csel=3, cwr, caddr_wr=0x7FF, data 20'h00ABC -> bank 3 entry 0x3FF=20'h00ABC; then crd, csel=3, caddr_rd=0x3FF -> cdata_rd=20'h00ABC; with the checker compiled in, err=1.
REQ-022 Illegal select: cwr with csel=6 -> no bank changes; err=1 only when CONV_HOST_PROTOCOL_CHECK_EN is defined.
REQ-023 Readback in DONE: rb_req, rb_sel=5, rb_addr=0x010 -> rb_valid=1 next cycle with the stored value; the same request during RUN -> rb_valid stays 0.
REQ-024 Reset during RUN: assert reset -> state IDLE, ready=0, done=0, cycles=0; memory still holds the value written earlier.
